// File: rtl/neuron_argmax_collector_pkg.sv
// Shared defaults and state encoding for the argmax collector and the classifier top.
package neuron_argmax_collector_pkg;

    localparam int PKG_NUM_CLASSES  = 10;
    localparam int PKG_OUTPUT_WIDTH = 26;
    localparam int PKG_CLASS_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/neuron_argmax_collector_score_compare.sv
// Combinational signed a > b; also reused by the classifier's result checker.
module score_compare #(
    parameter int WIDTH = 26
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             greater
);

    assign greater = $signed(a) > $signed(b);

endmodule

// File: rtl/neuron_argmax_collector.sv
// Captures all neuron scores once every neuron is done, scans them one per clock,
// and hands the winning class and score downstream over valid/ready.
module neuron_argmax_collector
    import neuron_argmax_collector_pkg::*;
#(
    parameter int NUM_CLASSES  = PKG_NUM_CLASSES,
    parameter int OUTPUT_WIDTH = PKG_OUTPUT_WIDTH,
    parameter int CLASS_WIDTH  = PKG_CLASS_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CLASSES*OUTPUT_WIDTH-1:0] IN_SCORES,
    input  logic [NUM_CLASSES-1:0]              IN_DONE,
    output logic [CLASS_WIDTH-1:0]              OUT_CLASS,
    output logic [OUTPUT_WIDTH-1:0]             OUT_SCORE,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic                                busy
);

    localparam logic [CLASS_WIDTH-1:0] LAST_PTR = CLASS_WIDTH'(NUM_CLASSES - 1);

    state_t                                   state_reg;
    logic                                     armed_reg;
    logic [CLASS_WIDTH-1:0]                   ptr_reg;
    logic [CLASS_WIDTH-1:0]                   idx_reg;
    logic [OUTPUT_WIDTH-1:0]                  best_reg;
    logic [NUM_CLASSES-1:0][OUTPUT_WIDTH-1:0] scores_reg;
    logic [NUM_CLASSES-1:0][OUTPUT_WIDTH-1:0] score_in;

    logic                    all_done;
    logic [OUTPUT_WIDTH-1:0] cand_score;
    logic                    cand_greater;
    logic [OUTPUT_WIDTH-1:0] best_next;
    logic [CLASS_WIDTH-1:0]  idx_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
            assign score_in[gi] = IN_SCORES[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH];
        end
    endgenerate

    assign all_done   = &IN_DONE;
    assign cand_score = scores_reg[ptr_reg];

    score_compare #(.WIDTH(OUTPUT_WIDTH)) u_compare (
        .a       (cand_score),
        .b       (best_reg),
        .greater (cand_greater)
    );

    // Strict greater-than keeps the lowest index on ties.
    assign best_next = cand_greater ? cand_score : best_reg;
    assign idx_next  = cand_greater ? ptr_reg    : idx_reg;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            armed_reg  <= 1'b1;
            ptr_reg    <= '0;
            idx_reg    <= '0;
            best_reg   <= '0;
            scores_reg <= '0;
            OUT_CLASS  <= '0;
            OUT_SCORE  <= '0;
            OUT_VALID  <= 1'b0;
        end else begin
            // Rearm only after done drops, so a held done vector yields one result.
            if (!all_done) begin
                armed_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (armed_reg && all_done) begin
                        scores_reg <= score_in;
                        best_reg   <= score_in[0];
                        idx_reg    <= '0;
                        ptr_reg    <= CLASS_WIDTH'(1);
                        armed_reg  <= 1'b0;
                        state_reg  <= SCAN;
                    end
                end
                SCAN: begin
                    best_reg <= best_next;
                    idx_reg  <= idx_next;
                    if (ptr_reg == LAST_PTR) begin
                        OUT_CLASS <= idx_next;
                        OUT_SCORE <= best_next;
                        OUT_VALID <= 1'b1;
                        state_reg <= RESULT;
                    end else begin
                        ptr_reg <= ptr_reg + CLASS_WIDTH'(1);
                    end
                end
                RESULT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_argmax_collector.sv
// Directed bench for neuron_argmax_collector: reset, argmax, ties, backpressure, rearm, mid-op events.
module tb_neuron_argmax_collector;

    localparam int N  = 10;
    localparam int W  = 26;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_scores;
    logic [N-1:0]    in_done;
    logic [CW-1:0]   out_class;
    logic [W-1:0]    out_score;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    int compared   = 0;
    int mismatched = 0;

    neuron_argmax_collector dut (
        .clk       (clk),
        .rst       (rst),
        .IN_SCORES (in_scores),
        .IN_DONE   (in_done),
        .OUT_CLASS (out_class),
        .OUT_SCORE (out_score),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_score(input int k, input logic [W-1:0] v);
        in_scores[k*W +: W] = v;
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int k = 0; k < N; k++) set_score(k, v);
    endtask

    task automatic do_capture();
        in_done = '0;
        tick();
        in_done = '1;
        tick();
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        int e;
        rst = 1'b0;
        in_done = '1;
        out_ready = 1'b1;
        set_all('0);
        repeat (3) tick();
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset_valid: got %0b expected 0", out_valid);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL reset_busy: got %0b expected 0", busy);
        end
        compared++;
        if (out_class !== 4'd0 || out_score !== 26'd0) begin
            mismatched++; $display("FAIL reset_outputs: got class=%0d score=%0h expected 0/0", out_class, out_score);
        end
        rst = 1'b1;
        tick();
        compared++;
        if (busy !== 1'b1) begin
            mismatched++; $display("FAIL reset_release_capture: got busy=%0b expected 1", busy);
        end
        wait_valid(e);
        compared++;
        if (e !== 9 || out_class !== 4'd0) begin
            mismatched++; $display("FAIL reset_first_result: got edges=%0d class=%0d expected 9/0", e, out_class);
        end
        $display("txn reset: class=%0d score=%0h edges=%0d", out_class, out_score, e);
        tick();
    endtask

    task automatic test_basic_argmax();
        int e;
        for (int k = 0; k < N; k++) set_score(k, W'(k << 18));
        out_ready = 1'b1;
        do_capture();
        compared++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++; $display("FAIL basic_capture: got busy=%0b valid=%0b expected 1/0", busy, out_valid);
        end
        wait_valid(e);
        compared++;
        if (e !== 9) begin
            mismatched++; $display("FAIL basic_latency: got %0d edges expected 9", e);
        end
        compared++;
        if (out_class !== 4'd9 || out_score !== 26'h0240000) begin
            mismatched++; $display("FAIL basic_result: got class=%0d score=%0h expected 9/240000", out_class, out_score);
        end
        $display("txn basic: class=%0d score=%0h edges=%0d", out_class, out_score, e);
        tick();
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL basic_valid_one_cycle: got valid=%0b busy=%0b expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_signed_tie();
        int e;
        set_all(W'(-(5 << 18)));
        set_score(3, '1);
        set_score(7, '1);
        out_ready = 1'b1;
        do_capture();
        wait_valid(e);
        compared++;
        if (out_valid !== 1'b1 || out_class !== 4'd3 || out_score !== 26'h3FFFFFF) begin
            mismatched++; $display("FAIL tie_negative: got valid=%0b class=%0d score=%0h expected 1/3/3ffffff", out_valid, out_class, out_score);
        end
        $display("txn tie_negative: class=%0d score=%0h", out_class, out_score);
        tick();
        set_all(26'd12345);
        do_capture();
        wait_valid(e);
        compared++;
        if (out_valid !== 1'b1 || out_class !== 4'd0 || out_score !== 26'd12345) begin
            mismatched++; $display("FAIL tie_all_equal: got valid=%0b class=%0d score=%0h expected 1/0/3039", out_valid, out_class, out_score);
        end
        $display("txn tie_all_equal: class=%0d score=%0h", out_class, out_score);
        tick();
    endtask

    task automatic test_backpressure_rearm();
        int e;
        int bad;
        set_all(26'd5);
        set_score(6, 26'd777);
        out_ready = 1'b0;
        do_capture();
        wait_valid(e);
        compared++;
        if (out_valid !== 1'b1 || out_class !== 4'd6 || out_score !== 26'd777) begin
            mismatched++; $display("FAIL bp_result: got valid=%0b class=%0d score=%0h expected 1/6/309", out_valid, out_class, out_score);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_class !== 4'd6 || out_score !== 26'd777) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        $display("txn backpressure: class=%0d score=%0h held 20 cycles", out_class, out_score);
        out_ready = 1'b1;
        tick();
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL bp_handshake: got valid=%0b busy=%0b expected 0/0", out_valid, busy);
        end
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++; $display("FAIL no_second_result: got %0d active cycles expected 0", bad);
        end
        compared++;
        if (out_class !== 4'd6 || out_score !== 26'd777) begin
            mismatched++; $display("FAIL result_kept: got class=%0d score=%0h expected 6/309", out_class, out_score);
        end
        set_score(2, 26'd9999);
        do_capture();
        wait_valid(e);
        compared++;
        if (out_valid !== 1'b1 || out_class !== 4'd2 || out_score !== 26'd9999) begin
            mismatched++; $display("FAIL rearm_result: got valid=%0b class=%0d score=%0h expected 1/2/270f", out_valid, out_class, out_score);
        end
        $display("txn rearm: class=%0d score=%0h", out_class, out_score);
        tick();
    endtask

    task automatic test_mid_scan_change();
        int e;
        set_all(26'd1);
        set_score(4, 26'd500);
        out_ready = 1'b1;
        do_capture();
        tick();
        tick();
        set_score(8, 26'd100000);
        in_done = '0;
        wait_valid(e);
        compared++;
        if (out_valid !== 1'b1 || out_class !== 4'd4 || out_score !== 26'd500) begin
            mismatched++; $display("FAIL mid_scan_capture: got valid=%0b class=%0d score=%0h expected 1/4/1f4", out_valid, out_class, out_score);
        end
        $display("txn mid_scan: class=%0d score=%0h", out_class, out_score);
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int e;
        int bad;
        set_all(26'd3);
        set_score(1, 26'd42);
        out_ready = 1'b1;
        do_capture();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL reset_mid_scan: got valid=%0b busy=%0b expected 0/0", out_valid, busy);
        end
        compared++;
        if (out_class !== 4'd0 || out_score !== 26'd0) begin
            mismatched++; $display("FAIL reset_mid_outputs: got class=%0d score=%0h expected 0/0", out_class, out_score);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++; $display("FAIL reset_hold: got %0d active cycles expected 0", bad);
        end
        rst = 1'b1;
        tick();
        compared++;
        if (busy !== 1'b1) begin
            mismatched++; $display("FAIL reset_rearmed: got busy=%0b expected 1", busy);
        end
        wait_valid(e);
        compared++;
        if (e !== 9 || out_class !== 4'd1 || out_score !== 26'd42) begin
            mismatched++; $display("FAIL reset_recovery: got edges=%0d class=%0d score=%0h expected 9/1/2a", e, out_class, out_score);
        end
        $display("txn reset_mid_scan: class=%0d score=%0h edges=%0d", out_class, out_score, e);
        tick();
    endtask

    task automatic test_max_width();
        int e;
        set_all(26'h2000000);
        set_score(5, 26'h1FFFFFF);
        out_ready = 1'b1;
        do_capture();
        wait_valid(e);
        compared++;
        if (out_valid !== 1'b1 || out_class !== 4'd5 || out_score !== 26'h1FFFFFF) begin
            mismatched++; $display("FAIL max_width: got valid=%0b class=%0d score=%0h expected 1/5/1ffffff", out_valid, out_class, out_score);
        end
        $display("txn max_width: class=%0d score=%0h", out_class, out_score);
        tick();
    endtask

    initial begin
        in_scores = '0;
        in_done   = '0;
        out_ready = 1'b0;
        rst       = 1'b0;
        test_reset();
        test_basic_argmax();
        test_signed_tie();
        test_backpressure_rearm();
        test_mid_scan_change();
        test_reset_mid_scan();
        test_max_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
